// File: rtl/time_entry_parser_if.sv
// Byte-stream input and set/alarm result bundle of the time entry parser.
// The parser takes the slave side; the terminal front end takes the master side.
interface time_entry_parser_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_flag;
  logic [16:0] alarm_time;
  logic        err;

  modport master (
    output in_data, in_valid,
    input  in_ready, set_flag, set_time, alarm_flag, alarm_time, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, set_flag, set_time, alarm_flag, alarm_time, err
  );
endinterface

// File: rtl/time_entry_parser.sv
// Parses "Thh:mm:ssA/P", "Ahh:mm:ssA/P" and "X" lines ended by CR into seconds-of-day updates.
// Results land two edges after CR is accepted; in_ready is low during the CALC and EMIT cycles.
module time_entry_parser #(
  parameter int unsigned COUNTER_MAX = 86399,
  parameter logic [7:0]  CMD_TIME    = 8'h54,
  parameter logic [7:0]  CMD_ALARM   = 8'h41,
  parameter logic [7:0]  CMD_ALOFF   = 8'h58,
  parameter logic [7:0]  TERM_CHAR   = 8'h0D
) (
  input logic                clock,
  input logic                reset,
  time_entry_parser_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FIELD, S_XWAIT, S_DRAIN, S_CALC, S_EMIT} state_t;

  localparam logic [1:0]  C_T    = 2'd0;
  localparam logic [1:0]  C_A    = 2'd1;
  localparam logic [1:0]  C_X    = 2'd2;
  localparam logic [16:0] TS_MAX = 17'(COUNTER_MAX);

  state_t      state_q, state_d;
  logic [3:0]  pos_q, pos_d;
  logic [1:0]  cmd_q, cmd_d;
  logic        err_q, err_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic        pm_q, pm_d;
  logic [16:0] ts_q, ts_d;
  logic        set_flag_q, set_flag_d;
  logic [16:0] set_time_q, set_time_d;
  logic        alarm_flag_q, alarm_flag_d;
  logic [16:0] alarm_time_q, alarm_time_d;
  logic        err_pulse_q, err_pulse_d;

  logic        in_ready;
  logic        acc;
  logic [7:0]  c;
  logic        char_ok;
  logic [4:0]  hour, h12;
  logic [5:0]  minute, second;
  logic [16:0] ts_raw;

  assign c   = bus.in_data;
  assign acc = bus.in_valid && in_ready;

  // Expected character class for each position of the time field.
  always_comb begin
    char_ok = 1'b0;
    unique case (pos_q)
      4'd0:             char_ok = c inside {[8'h30:8'h31]};
      4'd1, 4'd4, 4'd7: char_ok = c inside {[8'h30:8'h39]};
      4'd2, 4'd5:       char_ok = (c == 8'h3A);
      4'd3, 4'd6:       char_ok = c inside {[8'h30:8'h35]};
      4'd8:             char_ok = (c == 8'h41) || (c == 8'h50);
      4'd9:             char_ok = (c == TERM_CHAR);
      default:          char_ok = 1'b0;
    endcase
  end

  assign hour   = 5'(dig_q[0]) * 5'd10 + 5'(dig_q[1]);
  assign minute = 6'(dig_q[2]) * 6'd10 + 6'(dig_q[3]);
  assign second = 6'(dig_q[4]) * 6'd10 + 6'(dig_q[5]);
  assign h12    = (hour == 5'd12) ? 5'd0 : hour;
  assign ts_raw = 17'(h12) * 17'd3600 + 17'(minute) * 17'd60 + 17'(second)
                + (pm_q ? 17'd43200 : 17'd0);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    dig_d   = dig_q;
    pm_d    = pm_q;
    ts_d    = ts_q;
    unique case (state_q)
      S_IDLE: if (acc) begin
        pos_d = 4'd0;
        err_d = 1'b0;
        if (c == CMD_TIME || c == CMD_ALARM) begin
          state_d = S_FIELD;
          cmd_d   = (c == CMD_TIME) ? C_T : C_A;
        end else if (c == CMD_ALOFF) begin
          state_d = S_XWAIT;
          cmd_d   = C_X;
        end else if (c != TERM_CHAR) begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end
      end
      S_FIELD: if (acc) begin
        if (char_ok) begin
          pos_d = pos_q + 4'd1;
          unique case (pos_q)
            4'd0:    dig_d[0] = c[3:0];
            4'd1:    dig_d[1] = c[3:0];
            4'd3:    dig_d[2] = c[3:0];
            4'd4:    dig_d[3] = c[3:0];
            4'd6:    dig_d[4] = c[3:0];
            4'd7:    dig_d[5] = c[3:0];
            4'd8:    pm_d     = (c == 8'h50);
            4'd9:    state_d  = S_CALC;
            default: ;
          endcase
        end else begin
          // An early CR already ends the line, so there is nothing left to drain.
          err_d   = 1'b1;
          state_d = (c == TERM_CHAR) ? S_CALC : S_DRAIN;
        end
      end
      S_XWAIT: if (acc) begin
        if (c == TERM_CHAR) begin
          state_d = S_CALC;
        end else begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: if (acc && c == TERM_CHAR) state_d = S_CALC;
      S_CALC: begin
        ts_d    = ts_raw;
        state_d = S_EMIT;
        if (cmd_q != C_X && (hour == 5'd0 || hour > 5'd12 || ts_raw > TS_MAX)) err_d = 1'b1;
      end
      S_EMIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = !reset && (state_q == S_IDLE || state_q == S_FIELD ||
                              state_q == S_XWAIT || state_q == S_DRAIN);
    set_flag_d   = 1'b0;
    err_pulse_d  = 1'b0;
    set_time_d   = set_time_q;
    alarm_flag_d = alarm_flag_q;
    alarm_time_d = alarm_time_q;
    if (state_q == S_EMIT) begin
      if (err_q) begin
        err_pulse_d = 1'b1;
      end else begin
        unique case (cmd_q)
          C_T: begin
            set_flag_d = 1'b1;
            set_time_d = ts_q;
          end
          C_A: begin
            alarm_flag_d = 1'b1;
            alarm_time_d = ts_q;
          end
          C_X:     alarm_flag_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q        <= '0;
      cmd_q        <= C_T;
      err_q        <= 1'b0;
      dig_q        <= '0;
      pm_q         <= 1'b0;
      ts_q         <= '0;
      set_flag_q   <= 1'b0;
      set_time_q   <= '0;
      alarm_flag_q <= 1'b0;
      alarm_time_q <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      cmd_q        <= cmd_d;
      err_q        <= err_d;
      dig_q        <= dig_d;
      pm_q         <= pm_d;
      ts_q         <= ts_d;
      set_flag_q   <= set_flag_d;
      set_time_q   <= set_time_d;
      alarm_flag_q <= alarm_flag_d;
      alarm_time_q <= alarm_time_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.set_flag   = set_flag_q;
  assign bus.set_time   = set_time_q;
  assign bus.alarm_flag = alarm_flag_q;
  assign bus.alarm_time = alarm_time_q;
  assign bus.err        = err_pulse_q;
endmodule

// File: tb/tb_time_entry_parser.sv
// Directed bench for time_entry_parser: a table of command lines with expected results,
// plus hand sequences for mid-command reset and back-to-back lines under held in_valid.
module tb_time_entry_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  time_entry_parser_if bus();

  time_entry_parser dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       line;
    bit          exp_set;
    bit          exp_err;
    logic [16:0] exp_set_time;
    bit          exp_aflag;
    logic [16:0] exp_atime;
  } vec_t;

  vec_t        vq[$];
  logic [16:0] set_q[$];
  int          overlap = 0;
  int          longp   = 0;
  logic        prev_sf = 1'b0;
  logic        prev_er = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.set_flag) set_q.push_back(bus.set_time);
    if (bus.set_flag && bus.err) overlap++;
    if ((bus.set_flag && prev_sf) || (bus.err && prev_er)) longp++;
    prev_sf = bus.set_flag;
    prev_er = bus.err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input string l, input bit s, input bit e, input logic [16:0] st,
                     input bit af, input logic [16:0] at);
    vec_t v;
    v.line = l; v.exp_set = s; v.exp_err = e;
    v.exp_set_time = st; v.exp_aflag = af; v.exp_atime = at;
    vq.push_back(v);
  endtask

  // Presents each character with in_valid held high; returns #1 after the last accepting edge.
  task automatic send(input string s, input bit add_cr);
    string t;
    t = add_cr ? {s, "\015"} : s;
    for (int i = 0; i < t.len(); i++) begin
      int n;
      n = 0;
      bus.in_data  = t[i];
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        check("ready timeout", 32'(bus.in_ready), 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " in_ready"},   32'(bus.in_ready),   32'd0);
    check({tag, " set_flag"},   32'(bus.set_flag),   32'd0);
    check({tag, " set_time"},   32'(bus.set_time),   32'd0);
    check({tag, " alarm_flag"}, 32'(bus.alarm_flag), 32'd0);
    check({tag, " alarm_time"}, 32'(bus.alarm_time), 32'd0);
    check({tag, " err"},        32'(bus.err),        32'd0);
  endtask

  // Sends one CR-terminated line and checks the 5-sample window that follows the CR edge.
  task automatic run_line(input string tag, input vec_t v);
    logic [4:0] rdy_v, sf_v, er_v;
    send(v.line, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      rdy_v[k] = bus.in_ready;
      sf_v[k]  = bus.set_flag;
      er_v[k]  = bus.err;
    end
    check({tag, " ready window"}, 32'(rdy_v), (v.line.len() == 0) ? 32'h1F : 32'h1C);
    check({tag, " set_flag window"}, 32'(sf_v), v.exp_set ? 32'h04 : 32'h00);
    check({tag, " err window"}, 32'(er_v), v.exp_err ? 32'h04 : 32'h00);
    check({tag, " set_time"}, 32'(bus.set_time), 32'(v.exp_set_time));
    check({tag, " alarm_flag"}, 32'(bus.alarm_flag), 32'(v.exp_aflag));
    check({tag, " alarm_time"}, 32'(bus.alarm_time), 32'(v.exp_atime));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    add("T07:30:15A",  1, 0, 17'd27015, 0, 17'd0);
    add("A11:59:59P",  0, 0, 17'd27015, 1, 17'd86399);
    add("T12:00:00A",  1, 0, 17'd0,     1, 17'd86399);
    add("T12:00:00P",  1, 0, 17'd43200, 1, 17'd86399);
    add("T13:00:00A",  0, 1, 17'd43200, 1, 17'd86399);
    add("T00:10:00A",  0, 1, 17'd43200, 1, 17'd86399);
    add("T07:6x:00A",  0, 1, 17'd43200, 1, 17'd86399);
    add("Q",           0, 1, 17'd43200, 1, 17'd86399);
    add("",            0, 0, 17'd43200, 1, 17'd86399);
    add("X",           0, 0, 17'd43200, 0, 17'd86399);
    add("A01:00:00P",  0, 0, 17'd43200, 1, 17'd46800);
    add("Xz",          0, 1, 17'd43200, 1, 17'd46800);
    add("T09:05:0",    0, 1, 17'd43200, 1, 17'd46800);
    add("T12:59:59a",  0, 1, 17'd43200, 1, 17'd46800);
    add("T11:59:59P",  1, 0, 17'd86399, 1, 17'd46800);
    add("T10:00:00AZ", 0, 1, 17'd86399, 1, 17'd46800);

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after reset in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vq[i]) run_line($sformatf("v%0d", i), vq[i]);

    // Reset in the middle of a command discards it and clears every output.
    send("T07:3", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    begin
      vec_t v;
      v.line = "T01:02:03A"; v.exp_set = 1; v.exp_err = 0;
      v.exp_set_time = 17'd3723; v.exp_aflag = 0; v.exp_atime = 17'd0;
      run_line("post-reset", v);
    end

    // Next line's first char is held on the bus while CALC/EMIT run and must not be lost.
    set_q.delete();
    send("T05:00:00A\015T06:00:00A", 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("chained pulse count", 32'(set_q.size()), 32'd2);
    if (set_q.size() == 2) begin
      check("chained first set_time",  32'(set_q[0]), 32'd18000);
      check("chained second set_time", 32'(set_q[1]), 32'd21600);
    end

    check("set_flag/err overlap", 32'(overlap), 32'd0);
    check("pulse longer than one cycle", 32'(longp), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
